// File: rtl/player_round_scheduler.sv
// Round sequencer between six asynchronous player inputs and the shared game datapath.
// Synchronizes strobes/moves, collects one move per enabled player, then issues them round-robin.

module player_lane_sync #(
    parameter int MOVE_W      = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              strobe_in,
    input  logic [MOVE_W-1:0] move_in,
    output logic              strobe_sync,
    output logic [MOVE_W-1:0] move_sync
);
    logic [SYNC_STAGES-1:0]             strb_q, strb_d;
    logic [SYNC_STAGES-1:0][MOVE_W-1:0] mv_q, mv_d;

    // Move bits share the strobe's depth so the synchronized move is aligned with its edge.
    always_comb begin
        strb_d = {strb_q[SYNC_STAGES-2:0], strobe_in};
        mv_d   = {mv_q[SYNC_STAGES-2:0], move_in};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            strb_q <= '0;
            mv_q   <= '0;
        end else begin
            strb_q <= strb_d;
            mv_q   <= mv_d;
        end
    end

    assign strobe_sync = strb_q[SYNC_STAGES-1];
    assign move_sync   = mv_q[SYNC_STAGES-1];
endmodule

module player_round_scheduler #(
    parameter int NUM_PLAYERS = 6,
    parameter int MOVE_W      = 3,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 100000000
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_PLAYERS*MOVE_W-1:0] player_move,
    input  logic [NUM_PLAYERS-1:0]        player_strobe,
    input  logic [NUM_PLAYERS-1:0]        player_en,
    input  logic                          round_start,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [2:0]                    out_player,
    output logic [MOVE_W-1:0]             out_move,
    output logic                          out_last,
    output logic [NUM_PLAYERS-1:0]        collected,
    output logic                          round_busy,
    output logic                          round_done,
    output logic                          timed_out,
    output logic [3:0]                    state_out
);
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int IW    = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

    typedef enum logic [3:0] {
        IDLE    = 4'h1,
        COLLECT = 4'h2,
        ISSUE   = 4'h4,
        DONE    = 4'h8
    } state_t;

    logic [NUM_PLAYERS-1:0]             strobe_sync, rise;
    logic [NUM_PLAYERS-1:0][MOVE_W-1:0] move_sync;

    state_t                             state_q, state_d;
    logic [NUM_PLAYERS-1:0]             prev_q, prev_d;
    logic [NUM_PLAYERS-1:0]             en_q, en_d;
    logic [NUM_PLAYERS-1:0]             collected_q, collected_d;
    logic [NUM_PLAYERS-1:0]             pending_q, pending_d;
    logic [NUM_PLAYERS-1:0][MOVE_W-1:0] slot_q, slot_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    logic [2:0]                         rr_ptr_q, rr_ptr_d;
    logic [2:0]                         first_q, first_d;
    logic                               issued_q, issued_d;
    logic                               out_valid_q, out_valid_d;
    logic [2:0]                         out_player_q, out_player_d;
    logic [MOVE_W-1:0]                  out_move_q, out_move_d;
    logic                               out_last_q, out_last_d;
    logic                               timed_out_q, timed_out_d;
    logic                               round_done_q, round_done_d;
    logic                               round_busy_q, round_busy_d;

    logic [NUM_PLAYERS-1:0]             capture, coll_new, pend_new;
    logic [2:0]                         sel;
    logic                               goto_issue;

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_lane
        player_lane_sync #(
            .MOVE_W      (MOVE_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk         (clk),
            .reset_n     (reset_n),
            .strobe_in   (player_strobe[g]),
            .move_in     (player_move[g*MOVE_W +: MOVE_W]),
            .strobe_sync (strobe_sync[g]),
            .move_sync   (move_sync[g])
        );
    end

    // First set bit of m at or after start, wrapping around the player ring.
    function automatic logic [2:0] rr_pick(input logic [NUM_PLAYERS-1:0] m, input int start);
        logic [2:0] r;
        logic       hit;
        int         idx;
        r   = '0;
        hit = 1'b0;
        for (int k = 0; k < NUM_PLAYERS; k++) begin
            idx = (start + k) % NUM_PLAYERS;
            if (!hit && m[idx[IW-1:0]]) begin
                r   = 3'(idx);
                hit = 1'b1;
            end
        end
        return r;
    endfunction

    assign rise   = strobe_sync & ~prev_q;
    assign prev_d = strobe_sync;

    always_comb begin
        state_d      = state_q;
        en_d         = en_q;
        collected_d  = collected_q;
        pending_d    = pending_q;
        slot_d       = slot_q;
        cnt_d        = cnt_q;
        rr_ptr_d     = rr_ptr_q;
        first_d      = first_q;
        issued_d     = issued_q;
        out_valid_d  = out_valid_q;
        out_player_d = out_player_q;
        out_move_d   = out_move_q;
        out_last_d   = out_last_q;
        timed_out_d  = timed_out_q;
        capture      = '0;
        coll_new     = collected_q;
        pend_new     = pending_q;
        sel          = '0;
        goto_issue   = 1'b0;

        case (state_q)
            IDLE: begin
                if (round_start && (|player_en)) begin
                    en_d        = player_en;
                    slot_d      = '0;
                    collected_d = '0;
                    timed_out_d = 1'b0;
                    issued_d    = 1'b0;
                    cnt_d       = CNT_W'(TIMEOUT_CYC - 1);
                    state_d     = COLLECT;
                end
            end
            COLLECT: begin
                capture  = rise & en_q & ~collected_q;
                coll_new = collected_q | capture;
                for (int i = 0; i < NUM_PLAYERS; i++)
                    if (capture[i]) slot_d[i] = move_sync[i];
                collected_d = coll_new;
                // A final capture on the timeout cycle still counts as a complete round.
                if ((coll_new & en_q) == en_q) begin
                    goto_issue = 1'b1;
                end else if (cnt_q == '0) begin
                    timed_out_d = 1'b1;
                    if (|coll_new) goto_issue = 1'b1;
                    else           state_d    = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
                if (goto_issue) begin
                    sel          = rr_pick(coll_new, int'(rr_ptr_q));
                    pending_d    = coll_new;
                    out_valid_d  = 1'b1;
                    out_player_d = sel;
                    out_move_d   = slot_d[sel[IW-1:0]];
                    out_last_d   = ($countones(coll_new) == 1);
                    first_d      = sel;
                    issued_d     = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (out_valid_q && out_ready) begin
                    pend_new                      = pending_q;
                    pend_new[out_player_q[IW-1:0]] = 1'b0;
                    pending_d                     = pend_new;
                    if (pend_new == '0) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = DONE;
                    end else begin
                        sel          = rr_pick(pend_new, int'(out_player_q) + 1);
                        out_player_d = sel;
                        out_move_d   = slot_q[sel[IW-1:0]];
                        out_last_d   = ($countones(pend_new) == 1);
                    end
                end
            end
            DONE: begin
                if (issued_q) rr_ptr_d = 3'((int'(first_q) + 1) % NUM_PLAYERS);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        round_done_d = (state_d == DONE);
        round_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            prev_q       <= '0;
            en_q         <= '0;
            collected_q  <= '0;
            pending_q    <= '0;
            slot_q       <= '0;
            cnt_q        <= '0;
            rr_ptr_q     <= '0;
            first_q      <= '0;
            issued_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_player_q <= '0;
            out_move_q   <= '0;
            out_last_q   <= 1'b0;
            timed_out_q  <= 1'b0;
            round_done_q <= 1'b0;
            round_busy_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            en_q         <= en_d;
            collected_q  <= collected_d;
            pending_q    <= pending_d;
            slot_q       <= slot_d;
            cnt_q        <= cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            first_q      <= first_d;
            issued_q     <= issued_d;
            out_valid_q  <= out_valid_d;
            out_player_q <= out_player_d;
            out_move_q   <= out_move_d;
            out_last_q   <= out_last_d;
            timed_out_q  <= timed_out_d;
            round_done_q <= round_done_d;
            round_busy_q <= round_busy_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_player = out_player_q;
    assign out_move   = out_move_q;
    assign out_last   = out_last_q;
    assign collected  = collected_q;
    assign round_busy = round_busy_q;
    assign round_done = round_done_q;
    assign timed_out  = timed_out_q;
    assign state_out  = state_q;
endmodule
